terrain_scroll_strip: RTL and testbench



---
 rtl/terrain_scroll_strip.sv | 178 +++++++++++++++++
 tb/tb_terrain_scroll_strip.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/terrain_scroll_strip.sv
// terrain_scroll_strip
//   Draws a scaled 16x16, 2-bit-per-pixel terrain tile at a moving screen
//   position. The position advances once per frame, on the rising edge of
//   i_v_sync. There are two motion modes:
//     mode 0 : diagonal drift (left/down), respawns when the tile leaves the screen
//     mode 1 : horizontal scroll, wraps seamlessly around the screen edges
//   Pixel output is registered in two stages: i_x/i_y to outputs is 2 cycles.
//
// Ports
//   i_clk, i_rst_n         pixel clock, synchronous active-low reset
//   i_x, i_y               current pixel coordinate
//   i_v_sync               vertical sync (level, synchronous to i_clk)
//   i_active               motion enable
//   i_mode                 0 = diagonal/respawn, 1 = horizontal scroll/wrap
//   o_red/o_green/o_blue   pixel colour (0 outside the strip / transparent)
//   o_sprite_hit           opaque strip pixel
//   o_pos_x, o_pos_y       current top-left corner of the strip
//   o_wrapped              one-cycle pulse after a respawn or wrap
module terrain_scroll_strip #(
  parameter int          START_X      = 144,
  parameter int          START_Y      = 390,
  parameter int          SCALE_X_LOG2 = 4,
  parameter int          SCALE_Y_LOG2 = 1,
  parameter int          STEP_X       = 1,
  parameter int          STEP_Y       = 1,
  parameter int          SCREEN_W     = 1280,
  parameter int          SCREEN_H     = 720,
  parameter logic [23:0] EDGE_RGB     = 24'hA0A0A0,
  parameter logic [23:0] FILL_RGB     = 24'hA0A0A0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  input  logic        i_v_sync,
  input  logic        i_active,
  input  logic        i_mode,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue,
  output logic        o_sprite_hit,
  output logic [15:0] o_pos_x,
  output logic [15:0] o_pos_y,
  output logic        o_wrapped
);

  localparam logic [15:0] SX  = 16'(START_X);
  localparam logic [15:0] SY  = 16'(START_Y);
  localparam logic [15:0] DX  = 16'(STEP_X);
  localparam logic [15:0] DY  = 16'(STEP_Y);
  localparam logic [15:0] SW  = 16'(SCREEN_W);
  localparam logic [15:0] SH  = 16'(SCREEN_H);
  localparam logic [15:0] W16 = 16'(16 << SCALE_X_LOG2);
  localparam logic [15:0] H16 = 16'(16 << SCALE_Y_LOG2);

  // Tile bitmap. Each row is 16 two-bit indices, and column 0 sits in the MSBs.
  function automatic logic [31:0] rom_row(input logic [3:0] r);
    case (r)
      4'd5:    rom_row = 32'b00_00_00_01_01_01_01_01_01_01_01_01_00_00_00_00;
      4'd6:    rom_row = 32'b00_01_01_01_11_11_11_11_11_11_11_01_01_01_00_00;
      4'd7:    rom_row = 32'b01_10_11_11_11_11_11_11_11_11_11_11_11_11_01_00;
      4'd8:    rom_row = 32'b01_10_11_11_11_11_11_11_11_11_11_11_11_11_11_01;
      4'd9:    rom_row = 32'b00_01_10_10_10_10_10_10_10_10_10_10_10_10_10_01;
      4'd10:   rom_row = 32'b00_00_01_01_01_01_01_01_01_01_01_01_01_01_01_00;
      default: rom_row = 32'h0;
    endcase
  endfunction

  logic [15:0] pos_x, pos_y;
  logic        vsync_d;
  logic        tick;

  assign tick    = i_v_sync & ~vsync_d;
  assign o_pos_x = pos_x;
  assign o_pos_y = pos_y;

  // Frame motion. All decisions use the values from before the update.
  // vsync_d resets to 1, so a v_sync that is already high at reset release
  // does not produce a tick.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pos_x     <= SX;
      pos_y     <= SY;
      vsync_d   <= 1'b1;
      o_wrapped <= 1'b0;
    end else begin
      vsync_d   <= i_v_sync;
      o_wrapped <= 1'b0;
      if (tick && i_active) begin
        if (!i_mode) begin
          if (pos_x >= SW || pos_y >= SH) begin
            pos_x     <= SX;
            pos_y     <= SY;
            o_wrapped <= 1'b1;
          end else begin
            // An underflow here leaves a huge pos_x, which respawns on the next tick.
            pos_x <= pos_x - DX;
            pos_y <= pos_y + DY;
          end
        end else begin
          if (pos_x >= SW) begin
            pos_x     <= SX;
            o_wrapped <= 1'b1;
          end else if (pos_x < DX) begin
            pos_x     <= pos_x + SW - DX;
            o_wrapped <= 1'b1;
          end else begin
            pos_x <= pos_x - DX;
          end
        end
      end
    end
  end

  // Render stage 1: find the offset inside the strip and map it to a tile cell.
  logic [15:0] dx, dy;
  logic        hit_x, hit_y;

  always_comb begin
    dx    = i_x - pos_x;
    hit_x = (i_x >= pos_x) && (dx < W16);
    if (i_mode) begin
      // A pixel left of pos_x belongs to the part of the strip that wrapped
      // past the right screen edge.
      if (i_x < pos_x) dx = i_x + SW - pos_x;
      hit_x = (i_x < SW) && (dx < W16);
    end
    dy    = i_y - pos_y;
    hit_y = (i_y >= pos_y) && (dy < H16);
  end

  logic       s1_hit;
  logic [3:0] s1_col, s1_row;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_hit <= 1'b0;
      s1_col <= 4'd0;
      s1_row <= 4'd0;
    end else begin
      s1_hit <= hit_x & hit_y;
      s1_col <= dx[SCALE_X_LOG2 +: 4];
      s1_row <= dy[SCALE_Y_LOG2 +: 4];
    end
  end

  // Render stage 2: read the palette index from the ROM and apply the palette.
  logic [31:0] row_bits;
  logic [1:0]  idx;
  logic [23:0] rgb;

  always_comb begin
    row_bits = rom_row(s1_row);
    // Bit offset 2*(15-col), so that column 0 maps to the top two bits.
    idx      = row_bits[{~s1_col, 1'b0} +: 2];
    case (idx)
      2'd1, 2'd2: rgb = EDGE_RGB;
      2'd3:       rgb = FILL_RGB;
      default:    rgb = 24'h0;
    endcase
    if (!s1_hit) rgb = 24'h0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_red        <= 8'd0;
      o_green      <= 8'd0;
      o_blue       <= 8'd0;
      o_sprite_hit <= 1'b0;
    end else begin
      o_red        <= rgb[23:16];
      o_green      <= rgb[15:8];
      o_blue       <= rgb[7:0];
      o_sprite_hit <= s1_hit & (idx != 2'd0);
    end
  end

endmodule

// File: tb/tb_terrain_scroll_strip.sv
module tb_terrain_scroll_strip;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [15:0] i_x, i_y;
  logic        i_v_sync, i_active, i_mode;
  logic [7:0]  o_red, o_green, o_blue;
  logic        o_sprite_hit;
  logic [15:0] o_pos_x, o_pos_y;
  logic        o_wrapped;

  int n_chk  = 0;
  int n_fail = 0;

  terrain_scroll_strip dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_x(i_x), .i_y(i_y),
    .i_v_sync(i_v_sync), .i_active(i_active), .i_mode(i_mode),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_sprite_hit(o_sprite_hit), .o_pos_x(o_pos_x), .o_pos_y(o_pos_y),
    .o_wrapped(o_wrapped)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // One v_sync pulse: high for one cycle, then low for one cycle.
  task automatic tick(output logic w_pulse, output logic w_after);
    i_v_sync = 1'b1; step(1); w_pulse = o_wrapped;
    i_v_sync = 1'b0; step(1); w_after = o_wrapped;
  endtask

  task automatic ticks(input int n, output int nwrap);
    logic a, b;
    nwrap = 0;
    for (int k = 0; k < n; k++) begin
      tick(a, b);
      nwrap += int'(a) + int'(b);
    end
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic exp_hit);
    i_x = 16'(x); i_y = 16'(y);
    step(2);
    chk({tag, "_hit"}, 32'(o_sprite_hit), 32'(exp_hit));
    chk({tag, "_rgb"}, {8'h0, o_red, o_green, o_blue}, exp_hit ? 32'hA0A0A0 : 32'h0);
  endtask

  task automatic chk_pos(input string tag, input int x, input int y);
    chk({tag, "_x"}, 32'(o_pos_x), 32'(x));
    chk({tag, "_y"}, 32'(o_pos_y), 32'(y));
  endtask

  initial begin
    logic w1, w2;
    int   nw;
    i_rst_n = 1'b0; i_x = '0; i_y = '0;
    i_v_sync = 1'b0; i_active = 1'b0; i_mode = 1'b0;
    step(2);
    chk_pos("rst_pos", 144, 390);
    chk("rst_rgb", {8'h0, o_red, o_green, o_blue}, 32'h0);
    chk("rst_hit", 32'(o_sprite_hit), 32'h0);
    chk("rst_wrap", 32'(o_wrapped), 32'h0);
    i_rst_n = 1'b1;

    // Pixels at the reset position (144,390): W=256, H=32.
    pix("r7c0",   144, 404, 1'b1);  // idx 1
    pix("r7c1",   160, 404, 1'b1);  // idx 2
    pix("r7c15",  384, 404, 1'b0);  // idx 0
    pix("r8c15",  384, 406, 1'b1);  // idx 1
    pix("r10c0",  144, 410, 1'b0);
    pix("r10c2",  176, 410, 1'b1);
    pix("r0",     144, 390, 1'b0);
    pix("left",   143, 404, 1'b0);
    pix("right",  400, 404, 1'b0);

    // Mode 0 drift.
    i_active = 1'b1;
    ticks(10, nw);
    chk_pos("m0_10", 134, 400);
    chk("m0_10_nowrap", 32'(nw), 0);
    i_v_sync = 1'b1; step(5); i_v_sync = 1'b0; step(1);
    chk_pos("m0_held", 133, 401);
    ticks(133, nw);
    chk_pos("m0_zero", 0, 534);
    tick(w1, w2);
    chk_pos("m0_under", 65535, 535);
    chk("m0_under_nowrap", 32'(w1), 0);
    tick(w1, w2);
    chk_pos("m0_respawn", 144, 390);
    chk("m0_wrap_pulse", 32'(w1), 1);
    chk("m0_wrap_end", 32'(w2), 0);

    // Mode 1 scroll with wrap-around.
    i_mode = 1'b1;
    ticks(144, nw);
    chk_pos("m1_zero", 0, 390);
    chk("m1_nowrap", 32'(nw), 0);
    tick(w1, w2);
    chk_pos("m1_wrap", 1279, 390);
    chk("m1_wrap_pulse", 32'(w1), 1);
    chk("m1_wrap_end", 32'(w2), 0);
    pix("m1_x1279", 1279, 404, 1'b1);
    pix("m1_x0",    0,    404, 1'b1);
    pix("m1_x254",  254,  406, 1'b1);
    pix("m1_x255",  255,  404, 1'b0);
    pix("m1_x1280", 1280, 404, 1'b0);
    tick(w1, w2);
    chk_pos("m1_step", 1278, 390);
    chk("m1_step_nowrap", 32'(w1), 0);

    // Motion disabled.
    i_active = 1'b0;
    ticks(20, nw);
    chk_pos("idle", 1278, 390);
    chk("idle_nowrap", 32'(nw), 0);

    // Reset in the middle of a line, with v_sync high at release.
    i_active = 1'b1; i_mode = 1'b0;
    ticks(50, nw);
    chk_pos("m0_50", 1228, 440);
    i_x = 16'd144; i_y = 16'd404;
    i_v_sync = 1'b1; step(1);
    chk_pos("pre_rst", 1227, 441);
    i_rst_n = 1'b0; step(1);
    chk_pos("mid_rst_pos", 144, 390);
    chk("mid_rst_rgb", {8'h0, o_red, o_green, o_blue}, 32'h0);
    chk("mid_rst_hit", 32'(o_sprite_hit), 0);
    i_rst_n = 1'b1; step(1);
    chk("post_rst1_hit", 32'(o_sprite_hit), 0);
    chk("post_rst1_rgb", {8'h0, o_red, o_green, o_blue}, 32'h0);
    chk_pos("post_rst1_pos", 144, 390);
    step(1);
    chk("post_rst2_hit", 32'(o_sprite_hit), 1);
    chk_pos("post_rst2_pos", 144, 390);
    chk("post_rst2_wrap", 32'(o_wrapped), 0);
    i_v_sync = 1'b0; step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
